// File: rtl/refill_pkg.sv
// refill_pkg -- shared definitions for the cache line refill controller.
//
// Contents:
//   WORDS_DEFAULT / IDX_W_DEFAULT / TIMEOUT_DEFAULT : parameter defaults
//   state_t                                         : controller state encoding
//   wait_width()                                    : wait counter width for a timeout
package refill_pkg;

  localparam int WORDS_DEFAULT   = 8;   // words per cache line
  localparam int IDX_W_DEFAULT   = 3;   // log2(WORDS_DEFAULT)
  localparam int TIMEOUT_DEFAULT = 15;  // WAIT cycles allowed per word

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Bits needed to hold 0..timeout; never less than one bit.
  function automatic int wait_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/refill_word_counter.sv
// refill_word_counter -- index of the word currently being refilled.
//
// Ports:
//   clk    : clock, counts on rising edge
//   reset  : asynchronous active-high reset, clears the count
//   clr    : synchronous clear to 0 (has priority over en)
//   en     : advance by one; ignored once the last word is reached
//   count  : current word index
//   end_o  : high while count == WORDS-1
module refill_word_counter
  import refill_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             end_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  assign end_o = (count == LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its sources, independent of the
  // order in which always blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !end_o) begin
      // Saturates at the last word instead of wrapping back to 0.
      count <= count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/refill_ctrl.sv
// refill_ctrl -- sequences a WORDS-word cache line refill from memory.
//
// Per word: ISSUE (one-cycle mem_rd) -> WAIT (until mem_ack or timeout)
// -> WRITE (one-cycle line_we). After the last word a one-cycle done pulse;
// a word that times out produces a one-cycle err pulse instead.
//
// Ports:
//   clk      : clock
//   reset    : asynchronous active-high reset, abandons any refill
//   req      : refill request level, sampled only in IDLE
//   mem_ack  : memory word-valid acknowledge, honoured only in WAIT
//   mem_rd   : one-cycle memory read strobe
//   word_idx : index of the word being fetched or written
//   line_we  : one-cycle line write enable for word_idx
//   busy     : high in every state except IDLE
//   done     : one-cycle refill-complete pulse
//   err      : one-cycle timeout pulse
module refill_ctrl
  import refill_pkg::*;
#(
  parameter int WORDS   = WORDS_DEFAULT,
  parameter int IDX_W   = IDX_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic [IDX_W-1:0] word_idx,
  output logic             line_we,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int                WAIT_W    = wait_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic              word_clr;
  logic              word_en;
  logic              word_end;

  // wait_cnt holds the number of WAIT cycles already spent on this word, so
  // the TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
  assign wait_expired = (wait_cnt == WAIT_LAST);

  refill_word_counter #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_word_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (word_clr),
    .en    (word_en),
    .count (word_idx),
    .end_o (word_end)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        // Acknowledge is tested first so it wins over a same-cycle timeout.
        if (mem_ack) begin
          state_next = ST_WRITE;
        end else if (wait_expired) begin
          state_next = ST_ERR;
        end
      end
      ST_WRITE: state_next = word_end ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode and counter control; outputs depend on state only.
  always_comb begin
    mem_rd   = 1'b0;
    line_we  = 1'b0;
    busy     = (state != ST_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    word_clr = 1'b0;
    word_en  = 1'b0;
    unique case (state)
      ST_IDLE:  word_clr = req;
      ST_ISSUE: mem_rd   = 1'b1;
      ST_WAIT:  ;
      ST_WRITE: begin
        line_we = 1'b1;
        word_en = !word_end;
      end
      ST_DONE: begin
        done     = 1'b1;
        word_clr = 1'b1;
      end
      ST_ERR: begin
        err      = 1'b1;
        word_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-word wait counter: cleared in ISSUE, counts WAIT cycles, and holds
  // at its last value rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && !wait_expired) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_refill_ctrl.sv
// tb_refill_ctrl -- scoreboard bench for refill_ctrl.
//
// The stimulus task plans each refill from the word-level rules (ISSUE takes
// one cycle, WAIT lasts until the ack cycle or TIMEOUT cycles, WRITE one
// cycle) and queues the expected pulse events with their cycle numbers. A
// monitor pops and compares whenever the DUT shows a pulse output.
module tb_refill_ctrl;
  import refill_pkg::*;

  localparam int WORDS   = WORDS_DEFAULT;
  localparam int IDX_W   = IDX_W_DEFAULT;
  localparam int TIMEOUT = TIMEOUT_DEFAULT;

  typedef enum int {EV_RD = 0, EV_WE = 1, EV_DONE = 2, EV_ERR = 3} ev_kind_e;
  typedef struct {
    int       cyc;
    ev_kind_e kind;
    int       idx;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             mem_ack;
  logic             mem_rd;
  logic [IDX_W-1:0] word_idx;
  logic             line_we;
  logic             busy;
  logic             done;
  logic             err;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  last_done_cyc = -1;

  refill_ctrl #(
    .WORDS   (WORDS),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mem_ack  (mem_ack),
    .mem_rd   (mem_rd),
    .word_idx (word_idx),
    .line_we  (line_we),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse the DUT shows must be the next expected event.
  always @(negedge clk) begin
    int       n_pulse;
    ev_kind_e k;
    ev_t      e;
    n_pulse = int'(mem_rd === 1'b1) + int'(line_we === 1'b1)
            + int'(done === 1'b1) + int'(err === 1'b1);
    if (n_pulse > 0) begin
      k = (mem_rd === 1'b1) ? EV_RD : (line_we === 1'b1) ? EV_WE :
          (done === 1'b1) ? EV_DONE : EV_ERR;
      check("single_pulse", n_pulse, 1);
      if (k == EV_DONE) last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got kind %0d idx %0d expected none (cycle %0d)",
                 int'(k), word_idx, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", k, e.kind);
        check("ev_cycle", cyc, e.cyc);
        check("ev_word_idx", word_idx, e.idx);
      end
    end
  end

  function automatic bit in_list(input int c, input int lst[$]);
    foreach (lst[i]) if (lst[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_wait(input int c, input int lo[$], input int hi[$]);
    foreach (lo[i]) if (c >= lo[i] && c <= hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_line_we"}, line_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_word_idx"}, word_idx, 0);
  endtask

  // One refill. dly[k] is the WAIT cycle in which word k is acknowledged
  // (1..TIMEOUT); fail_word gets no ack at all; abort_word gets reset in its
  // second WAIT cycle. chained continues from a previous keep_req refill.
  task automatic do_refill(input int dly[WORDS], input int fail_word, input int abort_word,
                           input bit keep_req, input bit chained, input bit stray,
                           output int s0, output int end_c);
    int s;
    int first;
    int abort_c;
    int ack_c[$];
    int wait_lo[$];
    int wait_hi[$];
    ev_t keep[$];
    abort_c = -1;
    if (!chained) begin
      @(posedge clk);
      #1;
      req     = 1'b1;
      mem_ack = 1'b0;
    end
    first = cyc + 1;
    s0    = chained ? cyc + 2 : cyc + 1;

    // Plan the refill word by word.
    s     = s0;
    end_c = -1;
    for (int k = 0; k < WORDS; k++) begin
      exp_q.push_back(ev_t'{s, EV_RD, k});
      if (k == fail_word) begin
        wait_lo.push_back(s + 1);
        wait_hi.push_back(s + TIMEOUT);
        end_c = s + TIMEOUT + 1;
        exp_q.push_back(ev_t'{end_c, EV_ERR, k});
        break;
      end
      if (k == abort_word) abort_c = s + 2;
      wait_lo.push_back(s + 1);
      wait_hi.push_back(s + dly[k]);
      ack_c.push_back(s + dly[k]);
      exp_q.push_back(ev_t'{s + dly[k] + 1, EV_WE, k});
      s = s + dly[k] + 2;
    end
    if (end_c < 0) begin
      end_c = s;
      exp_q.push_back(ev_t'{end_c, EV_DONE, WORDS - 1});
    end
    if (abort_c >= 0) end_c = abort_c;

    // Drive cycle by cycle; inputs change 1 time unit after each edge.
    for (int c = first; c <= end_c; c++) begin
      @(posedge clk);
      #1;
      if (in_list(c, ack_c)) mem_ack = 1'b1;
      else if (stray && !in_wait(c, wait_lo, wait_hi)) mem_ack = 1'($urandom_range(0, 1));
      else mem_ack = 1'b0;
      if (c < s0) req = 1'b1;
      else if (keep_req) req = 1'b1;
      else if (stray && c != abort_c) req = 1'($urandom_range(0, 1));
      else req = 1'b0;
      if (c == s0) check("busy_in_refill", busy, 1);
      if (c == abort_c) begin
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        foreach (exp_q[i]) if (exp_q[i].cyc < abort_c) keep.push_back(exp_q[i]);
        exp_q = keep;
      end
    end

    if (abort_c >= 0) begin
      req     = 1'b0;
      mem_ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      check_outputs_zero("held_reset");
      reset = 1'b0;
    end else if (!keep_req) begin
      @(posedge clk);
      #1;
      req     = 1'b0;
      mem_ack = 1'b0;
      check("busy_after_refill", busy, 0);
      if (fail_word >= 0) check("word_idx_after_err", word_idx, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d[WORDS];
    int s0;
    int end_c;
    int end2;
    int fw;
    reset   = 1'b1;
    req     = 1'b0;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    #3;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Fast memory: ack in the first WAIT cycle of every word.
    foreach (d[i]) d[i] = 1;
    do_refill(d, -1, -1, 1'b0, 1'b0, 1'b0, s0, end_c);
    check("done_latency_fast", last_done_cyc - s0 + 1, 3 * WORDS + 1);

    // Slow memory: ack 5 cycles after each mem_rd.
    foreach (d[i]) d[i] = 5;
    do_refill(d, -1, -1, 1'b0, 1'b0, 1'b0, s0, end_c);
    check("done_latency_slow", last_done_cyc - s0 + 1, WORDS * (2 + 5) + 1);

    // Timeout on word 3.
    foreach (d[i]) d[i] = $urandom_range(1, TIMEOUT);
    do_refill(d, 3, -1, 1'b0, 1'b0, 1'b0, s0, end_c);

    // Ack in the last allowed WAIT cycle, plus stray acks/reqs elsewhere.
    foreach (d[i]) d[i] = (i % 2 == 0) ? TIMEOUT : 1;
    do_refill(d, -1, -1, 1'b0, 1'b0, 1'b1, s0, end_c);

    // Reset during WAIT of word 5, then a clean full refill.
    foreach (d[i]) d[i] = 3;
    do_refill(d, -1, 5, 1'b0, 1'b0, 1'b0, s0, end_c);
    repeat (2) @(posedge clk);
    foreach (d[i]) d[i] = 1;
    do_refill(d, -1, -1, 1'b0, 1'b0, 1'b0, s0, end_c);
    check("done_latency_after_reset", last_done_cyc - s0 + 1, 3 * WORDS + 1);

    // Back-to-back: req held through DONE starts the next refill.
    do_refill(d, -1, -1, 1'b1, 1'b0, 1'b0, s0, end_c);
    do_refill(d, -1, -1, 1'b0, 1'b1, 1'b0, s0, end2);
    check("back_to_back_start", s0 - end_c, 2);

    // Randomized refills, some with a timing-out word.
    for (int n = 0; n < 12; n++) begin
      foreach (d[i]) d[i] = $urandom_range(1, TIMEOUT);
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
      do_refill(d, fw, -1, 1'b0, 1'b0, 1'b1, s0, end_c);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1;
    check("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
